guess_matcher: RTL and testbench
================================

Name: guess_matcher

Overview:
- Word/guess datapath that sits directly downstream of the hangman game controller.
- Stores the secret word one letter at a time.
- On each guess, scans every stored position, reveals matching positions and streams them to the drawing stage.
- Keeps the miss count and reports match / continuous / complete / done / loaded back to the controller.

Parameters:
- LETTER_W, 5, width of a letter code (0=A .. 25=Z; codes 26-31 are invalid).
- MAX_LEN, 16, maximum word length.
- MAX_MISS, 6, number of misses that ends the game (hangman fully drawn).

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- wipe  in  1  synchronous clear of word, mask and miss count (new game)
- ld  in  1  write strobe: store char_in at the next word position
- char_in  in  LETTER_W  letter being loaded
- compare  in  1  start strobe: scan the word for guess
- guess  in  LETTER_W  guessed letter
- loaded  out  1  one-cycle pulse acknowledging ld
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at scan end
- match  out  1  last guess hit at least one position
- continuous  out  1  at least one position is still unrevealed
- complete  out  1  miss_count == MAX_MISS
- reveal_valid  out  1  reveal_idx/reveal_char valid this cycle
- reveal_idx  out  $clog2(MAX_LEN)  position being revealed
- reveal_char  out  LETTER_W  letter at that position
- word_len  out  $clog2(MAX_LEN+1)  letters stored
- miss_count  out  $clog2(MAX_MISS+1)  misses so far

Behaviour:
- Reset (resetn=0 at a clk edge):
  - All outputs go to 0.
  - Word memory contents are don't-care; reveal mask is cleared.
  - FSM goes to IDLE.
- wipe has the same effect as reset except that memory is retained. wipe has priority over ld and compare and aborts a scan in progress; no done pulse is issued for an aborted scan.
- FSM states: IDLE, SCAN, FINISH.
- Load (IDLE only):
  - ld=1 with word_len<MAX_LEN: write mem[word_len]=char_in, clear mask[word_len], word_len+1. loaded pulses the next cycle.
  - ld at word_len==MAX_LEN: write dropped, word_len unchanged, loaded still pulses so the controller does not hang.
  - ld with an invalid code (>25): dropped, loaded still pulses.
  - ld in SCAN or FINISH is ignored and no loaded pulse is issued.
- Compare (IDLE only):
  - compare=1 at cycle T latches guess, clears a hit flag, sets idx=0 and enters SCAN; busy=1 from T+1.
  - SCAN examines position idx during cycle T+1+idx, for idx 0..word_len-1.
  - If mem[idx]==guess_q and mask[idx]==0: set mask[idx], set hit, and drive reveal_valid=1, reveal_idx=idx, reveal_char=mem[idx] that same cycle.
  - After the last position the FSM enters FINISH at T+1+word_len.
  - word_len==0: SCAN is skipped and FINISH occurs at T+1.
- FINISH (one cycle):
  - done=1, busy=0.
  - match=hit.
  - If hit=0, miss_count increments, saturating at MAX_MISS.
  - continuous = OR of ~mask[0..word_len-1]; it is 0 when word_len==0.
  - complete updates with the new miss_count.
  - All three flags are valid in the done cycle and held until the next FINISH or wipe.
  - Next state: IDLE.
- compare while busy is ignored. Simultaneous ld and compare in IDLE: compare wins and ld is dropped without a loaded pulse.
- A guess that is already fully revealed: hit=0, but it is not a miss (see the optional feature). An already_hit flag is set during the scan when mem[idx]==guess_q and mask[idx]==1.

Optional Feature:
- Macro: REPEAT_GUESS_PENALTY_EN.
- Defined: a guess with hit=0 counts as a miss even if already_hit=1, so a repeated letter is penalised.
- Undefined: a guess with already_hit=1 and hit=0 leaves miss_count unchanged and reports match=1, so it is harmless to the controller.

Decomposition:
- Package hangman_pkg: LETTER_W, MAX_LEN, MAX_MISS defaults, the letter code constants (LETTER_A=0, LETTER_Z=25) and the FSM state enum.
- One sub-module, word_store: MAX_LEN x LETTER_W register file with a per-entry reveal mask bit. It has a synchronous write port, an asynchronous read port by index, a set-mask port and a clear-all-mask port.
- The FSM, counters and flags live in guess_matcher.

Test Plan:
- Load C,A,T (2,0,19) → three loaded pulses, word_len=3. Compare A at T → reveal_valid at T+2 with idx=1, char=0; done at T+4; match=1, continuous=1, miss_count=0.
- Same word, compare Z → no reveal; done at T+4, match=0, miss_count=1. Repeat Z six times → complete=1 and miss_count stays at 6.
- Word "TOOT": compare T → reveals at idx 0 and 3. Compare O → reveals at idx 1 and 2; continuous=0 at done.
- Repeat guess A on "CAT" → default build: match=1, miss_count unchanged. With REPEAT_GUESS_PENALTY_EN defined: match=0, miss_count+1.
- Boundaries:
  - 17 ld strobes with MAX_LEN=16 → word_len=16, 17 loaded pulses.
  - compare with word_len=0 → done at T+1, match=0, continuous=0.
- wipe asserted at T+2 of a scan → no done pulse; next cycle busy=0, miss_count=0, word_len=0, mask cleared. resetn=0 mid-scan → same result.

Source files
------------

// File: rtl/hangman_pkg.sv
// hangman_pkg: constants and types shared by the hangman word/guess datapath.
//   DEF_LETTER_W / DEF_MAX_LEN / DEF_MAX_MISS : default parameter values
//   LETTER_A / LETTER_Z                       : range of valid letter codes
//   gm_state_e                                : guess_matcher FSM state
package hangman_pkg;

  localparam int DEF_LETTER_W = 5;
  localparam int DEF_MAX_LEN  = 16;
  localparam int DEF_MAX_MISS = 6;

  localparam int LETTER_A = 0;
  localparam int LETTER_Z = 25;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_FINISH = 2'd2
  } gm_state_e;

endpackage

// File: rtl/guess_matcher_word_store.sv
// word_store: MAX_LEN x LETTER_W letter register file with one reveal-mask
// bit per entry.
//   clk        : clock
//   wr_en_i    : write wr_data_i at wr_idx_i and clear that entry's mask bit
//   wr_idx_i   : write position
//   wr_data_i  : letter to write
//   rd_idx_i   : asynchronous read position
//   rd_data_o  : letter at rd_idx_i
//   rd_mask_o  : mask bit at rd_idx_i
//   set_mask_i : set the mask bit at set_idx_i
//   set_idx_i  : position to reveal
//   clr_mask_i : clear every mask bit (highest priority)
//   mask_o     : whole mask vector
// Letter contents are never reset; only the mask is cleared.
module word_store #(
  parameter int LETTER_W = 5,
  parameter int MAX_LEN  = 16
) (
  input  logic                       clk,
  input  logic                       wr_en_i,
  input  logic [$clog2(MAX_LEN)-1:0] wr_idx_i,
  input  logic [LETTER_W-1:0]        wr_data_i,
  input  logic [$clog2(MAX_LEN)-1:0] rd_idx_i,
  output logic [LETTER_W-1:0]        rd_data_o,
  output logic                       rd_mask_o,
  input  logic                       set_mask_i,
  input  logic [$clog2(MAX_LEN)-1:0] set_idx_i,
  input  logic                       clr_mask_i,
  output logic [MAX_LEN-1:0]         mask_o
);

  logic [LETTER_W-1:0] mem_q [MAX_LEN];
  logic [MAX_LEN-1:0]  mask_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
  end

  // Set and write never target the same cycle (scan vs. load), so their
  // relative order below does not matter in practice.
  always_ff @(posedge clk) begin
    if (clr_mask_i) begin
      mask_q <= '0;
    end else begin
      if (set_mask_i) mask_q[set_idx_i] <= 1'b1;
      if (wr_en_i)    mask_q[wr_idx_i]  <= 1'b0;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];
  assign rd_mask_o = mask_q[rd_idx_i];
  assign mask_o    = mask_q;

endmodule

// File: rtl/guess_matcher.sv
// guess_matcher: stores the secret word, scans it once per guess, streams
// newly revealed positions and tracks the miss count for the controller.
// Optional build macro: REPEAT_GUESS_PENALTY_EN -- when defined, guessing a
// letter that is already fully revealed counts as a miss; when undefined it
// reports match=1 and leaves miss_count alone.
//   clk, resetn          : clock, synchronous active-low reset
//   wipe                 : new game (clears length, mask, misses, flags)
//   ld, char_in          : load strobe and letter; loaded acknowledges
//   compare, guess       : scan strobe and guessed letter
//   busy, done           : scan in progress / one-cycle end-of-scan pulse
//   match, continuous,
//   complete             : flags valid from the done cycle until next done
//   reveal_valid/idx/char: position revealed this cycle
//   word_len, miss_count : letters stored / misses so far
//   state_dbg            : current FSM state
//
// Handshake: ld and compare are single-cycle strobes accepted only in IDLE;
// every accepted-or-dropped ld in IDLE (without compare) gets exactly one
// loaded pulse the following cycle; each compare gets exactly one done
// pulse unless wipe/reset aborts it.
module guess_matcher
  import hangman_pkg::*;
#(
  parameter int LETTER_W = DEF_LETTER_W,
  parameter int MAX_LEN  = DEF_MAX_LEN,
  parameter int MAX_MISS = DEF_MAX_MISS
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         wipe,
  input  logic                         ld,
  input  logic [LETTER_W-1:0]          char_in,
  input  logic                         compare,
  input  logic [LETTER_W-1:0]          guess,
  output logic                         loaded,
  output logic                         busy,
  output logic                         done,
  output logic                         match,
  output logic                         continuous,
  output logic                         complete,
  output logic                         reveal_valid,
  output logic [$clog2(MAX_LEN)-1:0]   reveal_idx,
  output logic [LETTER_W-1:0]          reveal_char,
  output logic [$clog2(MAX_LEN+1)-1:0] word_len,
  output logic [$clog2(MAX_MISS+1)-1:0] miss_count,
  output gm_state_e                    state_dbg
);

  localparam int IDX_W  = $clog2(MAX_LEN);
  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int MISS_W = $clog2(MAX_MISS + 1);

  localparam logic [LEN_W-1:0]    MAX_LEN_L  = LEN_W'(MAX_LEN);
  localparam logic [MISS_W-1:0]   MAX_MISS_L = MISS_W'(MAX_MISS);
  localparam logic [LETTER_W-1:0] LETTER_Z_L = LETTER_W'(LETTER_Z);

  gm_state_e             state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [LETTER_W-1:0]   guess_q;
  logic                  hit_q, ah_q;
  logic [LEN_W-1:0]      word_len_q;
  logic [MISS_W-1:0]     miss_q;
  logic                  loaded_q, busy_q, done_q;
  logic                  match_q, cont_q, complete_q;

  logic [LETTER_W-1:0]   rd_data;
  logic                  rd_mask;
  logic [MAX_LEN-1:0]    mask_vec, mask_view, in_word;
  logic                  scanning, eq, hit_now, ah_now;
  logic                  hit_d, ah_d, match_d, miss_inc, cont_d;
  logic [MISS_W-1:0]     miss_d;
  logic                  last_pos, finish_now, store_ok, wr_en, clr_mask;

  assign scanning = (state_q == ST_SCAN);
  assign eq       = (rd_data == guess_q);
  assign hit_now  = scanning && eq && !rd_mask;
  assign ah_now   = scanning && eq && rd_mask;

  // Accumulated flags as they stand after this cycle; a compare on an empty
  // word reaches FINISH straight from IDLE with nothing hit.
  assign hit_d = scanning ? (hit_q | hit_now) : 1'b0;
  assign ah_d  = scanning ? (ah_q  | ah_now)  : 1'b0;

`ifdef REPEAT_GUESS_PENALTY_EN
  assign miss_inc = !hit_d;
  assign match_d  = hit_d;
`else
  assign miss_inc = !hit_d && !ah_d;
  assign match_d  = hit_d || ah_d;
`endif

  assign miss_d = (miss_inc && (miss_q != MAX_MISS_L)) ? miss_q + 1'b1 : miss_q;

  assign last_pos   = (LEN_W'(idx_q) + LEN_W'(1)) == word_len_q;
  assign finish_now = (state_q == ST_IDLE && compare && word_len_q == '0) ||
                      (scanning && last_pos);

  assign store_ok = (state_q == ST_IDLE) && ld && !compare &&
                    (word_len_q != MAX_LEN_L) && (char_in <= LETTER_Z_L);
  assign wr_en    = resetn && !wipe && store_ok;
  assign clr_mask = !resetn || wipe;

  // continuous must already reflect the bit being revealed on the last scan
  // cycle, since the flag is registered on the same edge as that mask write.
  always_comb begin
    mask_view = mask_vec;
    if (hit_now) mask_view[idx_q] = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      in_word[i] = (LEN_W'(i) < word_len_q);
    end
  end
  assign cont_d = |(~mask_view & in_word);

  word_store #(
    .LETTER_W (LETTER_W),
    .MAX_LEN  (MAX_LEN)
  ) u_store (
    .clk        (clk),
    .wr_en_i    (wr_en),
    .wr_idx_i   (word_len_q[IDX_W-1:0]),
    .wr_data_i  (char_in),
    .rd_idx_i   (idx_q),
    .rd_data_o  (rd_data),
    .rd_mask_o  (rd_mask),
    .set_mask_i (hit_now),
    .set_idx_i  (idx_q),
    .clr_mask_i (clr_mask),
    .mask_o     (mask_vec)
  );

  always_ff @(posedge clk) begin
    if (!resetn || wipe) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      guess_q    <= '0;
      hit_q      <= 1'b0;
      ah_q       <= 1'b0;
      word_len_q <= '0;
      miss_q     <= '0;
      loaded_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      match_q    <= 1'b0;
      cont_q     <= 1'b0;
      complete_q <= 1'b0;
    end else begin
      loaded_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (compare) begin
            guess_q <= guess;
            hit_q   <= 1'b0;
            ah_q    <= 1'b0;
            idx_q   <= '0;
            state_q <= ST_SCAN;
            busy_q  <= 1'b1;
          end else if (ld) begin
            loaded_q <= 1'b1;
            if (store_ok) word_len_q <= word_len_q + 1'b1;
          end
        end
        ST_SCAN: begin
          hit_q <= hit_d;
          ah_q  <= ah_d;
          idx_q <= idx_q + 1'b1;
        end
        ST_FINISH: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
      if (finish_now) begin
        state_q    <= ST_FINISH;
        busy_q     <= 1'b0;
        done_q     <= 1'b1;
        match_q    <= match_d;
        cont_q     <= cont_d;
        miss_q     <= miss_d;
        complete_q <= (miss_d == MAX_MISS_L);
      end
    end
  end

  assign loaded       = loaded_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign match        = match_q;
  assign continuous   = cont_q;
  assign complete     = complete_q;
  assign reveal_valid = hit_now;
  assign reveal_idx   = hit_now ? idx_q : '0;
  assign reveal_char  = hit_now ? rd_data : '0;
  assign word_len     = word_len_q;
  assign miss_count   = miss_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_guess_matcher.sv
// Directed testbench for guess_matcher (default parameters). Build with
// +define+REPEAT_GUESS_PENALTY_EN to check the penalty variant.
module tb_guess_matcher;
  import hangman_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       wipe = 1'b0;
  logic       ld = 1'b0;
  logic [4:0] char_in = '0;
  logic       compare = 1'b0;
  logic [4:0] guess = '0;
  logic       loaded, busy, done, match, continuous, complete, reveal_valid;
  logic [3:0] reveal_idx;
  logic [4:0] reveal_char;
  logic [4:0] word_len;
  logic [2:0] miss_count;
  gm_state_e  state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  // Observed and expected reveal events, packed as {cycle, idx, char}.
  logic [15:0] rev_q[$];
  logic [15:0] exp_q[$];
  int          word_q[$];

  int         d_cyc;
  logic       d_match, d_cont, d_complete, d_busy_first, d_busy_done, saw_loaded;
  logic [2:0] d_miss;
  int         exp_miss;
  int         pulses;

  always #5 clk = ~clk;

  guess_matcher dut (
    .clk          (clk),
    .resetn       (resetn),
    .wipe         (wipe),
    .ld           (ld),
    .char_in      (char_in),
    .compare      (compare),
    .guess        (guess),
    .loaded       (loaded),
    .busy         (busy),
    .done         (done),
    .match        (match),
    .continuous   (continuous),
    .complete     (complete),
    .reveal_valid (reveal_valid),
    .reveal_idx   (reveal_idx),
    .reveal_char  (reveal_char),
    .word_len     (word_len),
    .miss_count   (miss_count),
    .state_dbg    (state_dbg)
  );

  function automatic logic [15:0] rv(input int c, input int idx, input int ch);
    rv = {1'b0, c[5:0], idx[3:0], ch[4:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wipe_pulse();
    wipe = 1'b1;
    step();
    wipe = 1'b0;
  endtask

  // Loads word_q back to back; counts loaded pulses seen one cycle after each ld.
  task automatic load_seq(output int npulse);
    npulse = 0;
    foreach (word_q[i]) begin
      ld = 1'b1;
      char_in = 5'(word_q[i]);
      step();
      if (loaded) npulse++;
    end
    ld = 1'b0;
    step();
  endtask

  // Pulses compare in cycle T; c counts cycles after T. Captures reveals and
  // the flags present in the done cycle, then steps back to IDLE.
  task automatic run_compare(input logic [4:0] g, input logic ld_too);
    rev_q.delete();
    d_cyc = -1;
    saw_loaded = 1'b0;
    d_busy_first = 1'b0;
    compare = 1'b1;
    guess = g;
    ld = ld_too;
    char_in = 5'd7;
    step();
    compare = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 1) d_busy_first = busy;
      if (loaded) saw_loaded = 1'b1;
      if (reveal_valid) rev_q.push_back(rv(c, int'(reveal_idx), int'(reveal_char)));
      if (done) begin
        d_cyc = c;
        d_match = match;
        d_cont = continuous;
        d_complete = complete;
        d_miss = miss_count;
        d_busy_done = busy;
        break;
      end
      step();
    end
    ld = 1'b0;
    n_checks++;
    if (d_cyc < 0) $display("FAIL done_timeout guess=%0d no done within 60 cycles", g);
    else n_pass++;
    step();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step();
    step();
    n_checks++;
    if ({loaded, busy, done, match, continuous, complete, reveal_valid, reveal_idx,
         reveal_char, word_len, miss_count} !== '0)
      $display("FAIL reset_outputs got busy=%b done=%b len=%0d miss=%0d want all zero",
               busy, done, word_len, miss_count);
    else n_pass++;
    n_checks++;
    if (state_dbg !== ST_IDLE) $display("FAIL reset_state got %0d want %0d", state_dbg, ST_IDLE);
    else n_pass++;
    resetn = 1'b1;
    step();
  endtask

  task automatic test_load_cat();
    word_q = {};
    word_q.push_back(2); word_q.push_back(0); word_q.push_back(19);
    load_seq(pulses);
    n_checks++;
    if (pulses != 3) $display("FAIL cat_loaded got %0d want 3", pulses); else n_pass++;
    n_checks++;
    if (word_len !== 5'd3) $display("FAIL cat_len got %0d want 3", word_len); else n_pass++;
  endtask

  task automatic test_hit_a();
    run_compare(5'd0, 1'b0);
    n_checks++;
    if (d_cyc != 4) $display("FAIL hit_done_cycle got %0d want 4", d_cyc); else n_pass++;
    n_checks++;
    if (rev_q.size() != 1 || rev_q[0] !== rv(2, 1, 0))
      $display("FAIL hit_reveal got n=%0d first=%h want n=1 %h", rev_q.size(),
               (rev_q.size() > 0) ? rev_q[0] : 16'hffff, rv(2, 1, 0));
    else n_pass++;
    n_checks++;
    if ({d_match, d_cont, d_miss} !== {1'b1, 1'b1, 3'd0})
      $display("FAIL hit_flags got m=%b c=%b miss=%0d want 1 1 0", d_match, d_cont, d_miss);
    else n_pass++;
    n_checks++;
    if ({d_busy_first, d_busy_done} !== 2'b10)
      $display("FAIL hit_busy got first=%b at_done=%b want 1 0", d_busy_first, d_busy_done);
    else n_pass++;
    exp_miss = 0;
  endtask

  task automatic test_repeat_guess();
    logic exp_match;
`ifdef REPEAT_GUESS_PENALTY_EN
    exp_match = 1'b0;
    exp_miss = exp_miss + 1;
`else
    exp_match = 1'b1;
`endif
    run_compare(5'd0, 1'b0);
    n_checks++;
    if (rev_q.size() != 0) $display("FAIL repeat_reveals got %0d want 0", rev_q.size());
    else n_pass++;
    n_checks++;
    if (d_match !== exp_match || d_miss !== 3'(exp_miss))
      $display("FAIL repeat_flags got m=%b miss=%0d want m=%b miss=%0d",
               d_match, d_miss, exp_match, exp_miss);
    else n_pass++;
  endtask

  task automatic test_miss_saturate();
    for (int k = 0; k < 7; k++) begin
      run_compare(5'd25, 1'b0);
      if (exp_miss < 6) exp_miss++;
      n_checks++;
      if (d_cyc != 4 || d_match !== 1'b0 || rev_q.size() != 0)
        $display("FAIL miss_%0d_scan got cyc=%0d m=%b n=%0d want 4 0 0",
                 k, d_cyc, d_match, rev_q.size());
      else n_pass++;
      n_checks++;
      if (d_miss !== 3'(exp_miss) || d_complete !== (exp_miss == 6))
        $display("FAIL miss_%0d_count got miss=%0d comp=%b want miss=%0d comp=%b",
                 k, d_miss, d_complete, exp_miss, exp_miss == 6);
      else n_pass++;
    end
  endtask

  task automatic test_toot();
    wipe_pulse();
    n_checks++;
    if ({word_len, miss_count, complete} !== '0)
      $display("FAIL wipe_clear got len=%0d miss=%0d comp=%b want 0 0 0",
               word_len, miss_count, complete);
    else n_pass++;
    word_q = {};
    word_q.push_back(19); word_q.push_back(14); word_q.push_back(14); word_q.push_back(19);
    load_seq(pulses);
    n_checks++;
    if (pulses != 4 || word_len !== 5'd4)
      $display("FAIL toot_load got pulses=%0d len=%0d want 4 4", pulses, word_len);
    else n_pass++;

    run_compare(5'd19, 1'b0);
    exp_q = {};
    exp_q.push_back(rv(1, 0, 19)); exp_q.push_back(rv(4, 3, 19));
    n_checks++;
    if (rev_q.size() != exp_q.size())
      $display("FAIL toot_t_count got %0d want %0d", rev_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= rev_q.size() || rev_q[i] !== exp_q[i])
        $display("FAIL toot_t_reveal%0d got %h want %h", i,
                 (i < rev_q.size()) ? rev_q[i] : 16'hffff, exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if ({d_cyc == 5, d_match, d_cont} !== 3'b111)
      $display("FAIL toot_t_flags got cyc=%0d m=%b c=%b want 5 1 1", d_cyc, d_match, d_cont);
    else n_pass++;

    run_compare(5'd14, 1'b0);
    exp_q = {};
    exp_q.push_back(rv(2, 1, 14)); exp_q.push_back(rv(3, 2, 14));
    n_checks++;
    if (rev_q.size() != exp_q.size())
      $display("FAIL toot_o_count got %0d want %0d", rev_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= rev_q.size() || rev_q[i] !== exp_q[i])
        $display("FAIL toot_o_reveal%0d got %h want %h", i,
                 (i < rev_q.size()) ? rev_q[i] : 16'hffff, exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if ({d_match, d_cont} !== 2'b10)
      $display("FAIL toot_o_flags got m=%b c=%b want 1 0", d_match, d_cont);
    else n_pass++;
  endtask

  task automatic test_full_word();
    wipe_pulse();
    word_q = {};
    for (int i = 0; i < 17; i++) word_q.push_back(i);
    load_seq(pulses);
    n_checks++;
    if (pulses != 17 || word_len !== 5'd16)
      $display("FAIL full_load got pulses=%0d len=%0d want 17 16", pulses, word_len);
    else n_pass++;
    // Letter 16 was the dropped 17th write, so it must not be found.
    run_compare(5'd16, 1'b0);
    n_checks++;
    if (d_cyc != 17 || d_match !== 1'b0 || rev_q.size() != 0 || d_miss !== 3'd1)
      $display("FAIL full_drop got cyc=%0d m=%b n=%0d miss=%0d want 17 0 0 1",
               d_cyc, d_match, rev_q.size(), d_miss);
    else n_pass++;
    run_compare(5'd15, 1'b0);
    n_checks++;
    if (rev_q.size() != 1 || rev_q[0] !== rv(16, 15, 15) || d_cont !== 1'b1)
      $display("FAIL full_last got n=%0d first=%h c=%b want 1 %h 1", rev_q.size(),
               (rev_q.size() > 0) ? rev_q[0] : 16'hffff, d_cont, rv(16, 15, 15));
    else n_pass++;
  endtask

  task automatic test_invalid_and_empty();
    wipe_pulse();
    word_q = {};
    word_q.push_back(30);
    load_seq(pulses);
    n_checks++;
    if (pulses != 1 || word_len !== 5'd0)
      $display("FAIL invalid_ld got pulses=%0d len=%0d want 1 0", pulses, word_len);
    else n_pass++;
    run_compare(5'd0, 1'b0);
    n_checks++;
    if (d_cyc != 1 || d_match !== 1'b0 || d_cont !== 1'b0 || d_miss !== 3'd1)
      $display("FAIL empty_cmp got cyc=%0d m=%b c=%b miss=%0d want 1 0 0 1",
               d_cyc, d_match, d_cont, d_miss);
    else n_pass++;
  endtask

  task automatic test_ld_ignored();
    wipe_pulse();
    word_q = {};
    word_q.push_back(2); word_q.push_back(0); word_q.push_back(19);
    load_seq(pulses);
    // ld held high with compare and throughout the scan.
    run_compare(5'd2, 1'b1);
    n_checks++;
    if (saw_loaded !== 1'b0 || word_len !== 5'd3)
      $display("FAIL ld_during_scan got loaded=%b len=%0d want 0 3", saw_loaded, word_len);
    else n_pass++;
    n_checks++;
    if (rev_q.size() != 1 || rev_q[0] !== rv(1, 0, 2))
      $display("FAIL ld_scan_reveal got n=%0d want 1 %h", rev_q.size(), rv(1, 0, 2));
    else n_pass++;
  endtask

  task automatic test_abort(input logic use_reset);
    logic saw_done;
    wipe_pulse();
    word_q = {};
    word_q.push_back(2); word_q.push_back(0); word_q.push_back(19);
    load_seq(pulses);
    run_compare(5'd25, 1'b0);
    saw_done = 1'b0;
    compare = 1'b1;
    guess = 5'd0;
    step();
    compare = 1'b0;
    step();
    if (use_reset) resetn = 1'b0; else wipe = 1'b1;
    step();
    resetn = 1'b1;
    wipe = 1'b0;
    n_checks++;
    if ({busy, done, reveal_valid, miss_count, word_len} !== '0)
      $display("FAIL abort%0d_state got busy=%b done=%b miss=%0d len=%0d want all zero",
               use_reset, busy, done, miss_count, word_len);
    else n_pass++;
    for (int c = 0; c < 6; c++) begin
      if (done) saw_done = 1'b1;
      step();
    end
    n_checks++;
    if (saw_done !== 1'b0) $display("FAIL abort%0d_done got 1 want 0", use_reset);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load_cat();
    test_hit_a();
    test_repeat_guess();
    test_miss_saturate();
    test_toot();
    test_full_word();
    test_invalid_and_empty();
    test_ld_ignored();
    test_abort(1'b0);
    test_abort(1'b1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
